// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for the bit-serial add/subtract sequencer
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [1:0]       op;
    logic             carry_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, carry_in, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op, carry_in, a, b,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial add/sub/adc/pass sequencer around one shared 1-bit full adder
module addbit (
    output logic out,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);
    assign out  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADC  = 2'b10;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_a_q, sh_a_d;
    logic [WIDTH-1:0]  sh_b_q, sh_b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic              sum_bit;
    logic              sum_cout;
    logic [WIDTH-1:0]  acc_shift;
    logic              last_bit;

    addbit u_addbit (
        .out  (sum_bit),
        .cout (sum_cout),
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q)
    );

    assign acc_shift = {sum_bit, acc_q[WIDTH-1:1]};
    assign last_bit  = (count_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        count_d  = count_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sh_a_d  = bus.a;
                    acc_d   = '0;
                    count_d = '0;
                    case (bus.op)
                        OP_ADD: begin sh_b_d = bus.b;  carry_d = 1'b0;         end
                        OP_SUB: begin sh_b_d = ~bus.b; carry_d = 1'b1;         end
                        OP_ADC: begin sh_b_d = bus.b;  carry_d = bus.carry_in; end
                        default: begin sh_b_d = '0;    carry_d = 1'b0;         end
                    endcase
                    state_d = RUN;
                end
            end
            RUN: begin
                sh_a_d  = sh_a_q >> 1;
                sh_b_d  = sh_b_q >> 1;
                acc_d   = acc_shift;
                carry_d = sum_cout;
                count_d = count_q + CW'(1);
                // Outputs are loaded only on the final bit so they never show a partial sum.
                if (last_bit) begin
                    result_d = acc_shift;
                    cout_d   = sum_cout;
                    ovf_d    = carry_q ^ sum_cout;
                    zero_d   = (acc_shift == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input bit inject,
                         input logic [7:0] exp_res, input logic exp_cout,
                         input logic exp_ovf, input logic exp_zero);
        logic [9:0] busy_vec;
        logic [9:0] done_vec;
        busy_vec = '0;
        done_vec = '0;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.carry_in = cin;
        bus.start    = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start    = inject && (k == 3 || k == 9);
            bus.a        = 8'($urandom_range(0, 255));
            bus.b        = 8'($urandom_range(0, 255));
            bus.op       = 2'($urandom_range(0, 3));
            bus.carry_in = 1'($urandom_range(0, 1));
            busy_vec[k-1] = bus.busy;
            done_vec[k-1] = bus.done;
            if (k == 9) begin
                check({tag, " result"}, 32'(bus.result), 32'(exp_res));
                check({tag, " cout"},   32'(bus.cout),   32'(exp_cout));
                check({tag, " ovf"},    32'(bus.ovf),    32'(exp_ovf));
                check({tag, " zero"},   32'(bus.zero),   32'(exp_zero));
            end
            if (k == 10) begin
                check({tag, " result held"}, 32'(bus.result), 32'(exp_res));
            end
        end
        bus.start = 1'b0;
        check({tag, " busy cycles"}, 32'(busy_vec), 32'h0FF);
        check({tag, " done cycles"}, 32'(done_vec), 32'h100);
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.a        = '0;
        bus.b        = '0;
        bus.carry_in = 1'b0;

        repeat (2) @(negedge clk);
        check("rst busy",   32'(bus.busy),   32'd0);
        check("rst done",   32'(bus.done),   32'd0);
        check("rst result", 32'(bus.result), 32'd0);
        check("rst zero",   32'(bus.zero),   32'd1);
        check("rst cout",   32'(bus.cout),   32'd0);
        check("rst ovf",    32'(bus.ovf),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("add 25+1a", 2'b00, 8'h25, 8'h1A, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b0, 1'b0);
        do_op("add ff+01", 2'b00, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op("sub 80-01", 2'b01, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
        do_op("sub 05-07", 2'b01, 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op("adc 7f+00+1", 2'b10, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("adc 10+20+0", 2'b10, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op("pass 00", 2'b11, 8'h00, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        do_op("pass c3", 2'b11, 8'hC3, 8'hFF, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
        do_op("ignore starts", 2'b00, 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0, 1'b0);
        check("idle after done", 32'(bus.busy), 32'd0);
        do_op("b2b sub 10-10", 2'b01, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Abort mid-run: async reset must clear outputs without waiting for a clock.
        bus.op    = 2'b00;
        bus.a     = 8'hF0;
        bus.b     = 8'h0F;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-run busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy",   32'(bus.busy),   32'd0);
        check("abort done",   32'(bus.done),   32'd0);
        check("abort result", 32'(bus.result), 32'd0);
        check("abort zero",   32'(bus.zero),   32'd1);
        repeat (2) @(negedge clk);
        check("abort no done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post-rst add 01+01", 2'b00, 8'h01, 8'h01, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
